// File: rtl/ms_seq_pkg.sv
// ms_seq_pkg: shared types and constants for the multi-step command sequencer
package ms_seq_pkg;
  typedef enum logic [1:0] {UIdle, UReq, UHeld, URel} unity_st_t;
  localparam int STEP_W_DEF = 10;
  localparam int PPL_W_DEF = 16;
  localparam logic [1:0] CMD_LEN_NONE = 2'd0;
  localparam logic [1:0] CMD_LEN_ONE = 2'd1;
  localparam logic [1:0] CMD_LEN_TWO = 2'd2;
  localparam logic [1:0] CMD_LEN_THREE = 2'd3;
endpackage

// File: rtl/ms_unity_hs.sv
// ms_unity_hs: 4-phase unity resource handshake between decoder and core arbiter
module ms_unity_hs
  import ms_seq_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_req,
  input  logic i_len_valid,
  input  logic i_retire,
  input  logic i_flush,
  input  logic i_gnt,
  output logic o_unity_req,
  output logic o_ack
);
  unity_st_t r_state;
  unity_st_t w_next;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= UIdle;
    else if (i_en) r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      UIdle: w_next = (i_req && i_len_valid && !i_flush) ? UReq : UIdle;
      UReq:  w_next = i_flush ? URel : (i_gnt ? UHeld : UReq);
      UHeld: w_next = (i_flush || !i_req || i_retire) ? URel : UHeld;
      URel:  w_next = i_gnt ? URel : UIdle;
      default: w_next = UIdle;
    endcase
  end
  // Moore decode of the state register keeps both outputs glitch-free
  always_comb begin
    o_unity_req = (r_state == UReq) || (r_state == UHeld);
    o_ack = r_state == UHeld;
  end
endmodule

// File: rtl/ms_cmd_seq.sv
// ms_cmd_seq: multi-step command sequencer; MS_STEP_WDOG_EN adds a non-retire watchdog
module ms_cmd_seq
  import ms_seq_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEF,
  parameter int PPL_W = PPL_W_DEF,
  parameter int WDOG_LIMIT = 1023
) (
  input  logic              AClkH,
  input  logic              AResetHN,
  input  logic              AClkHEn,
  input  logic [1:0]        AQueWords,
  input  logic [1:0]        ACmdLen,
  output logic              ACmdLenValid,
  output logic [STEP_W-1:0] AStepThis,
  input  logic [STEP_W-1:0] AStepNext,
  output logic [PPL_W-1:0]  APplListThis,
  input  logic [PPL_W-1:0]  APplListNext,
  input  logic              ADecUnityReq,
  output logic              ADecUnityAck,
  output logic              AUnityReq,
  input  logic              AUnityGnt,
  input  logic              AMemPend,
  input  logic              AFlush,
  output logic [1:0]        AQuePop,
  output logic              AIpAdv,
  output logic              ACmdBusy,
  output logic              AWdogTrap
);
  localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);
  logic [STEP_W-1:0] r_step;
  logic [PPL_W-1:0] r_ppl;
  logic w_ack, w_len_valid, w_ublock, w_adv, w_retire, w_trap;
  assign w_len_valid = (ACmdLen != CMD_LEN_NONE) && (AQueWords >= ACmdLen);
  assign w_ublock = ADecUnityReq && !w_ack;
  assign w_adv = AClkHEn && w_len_valid && !AMemPend && !w_ublock && !AFlush && !w_trap;
  assign w_retire = w_adv && (AStepNext == '0);
  assign ACmdLenValid = w_len_valid;
  assign ADecUnityAck = w_ack;
  assign AQuePop = w_retire ? ACmdLen : 2'd0;
  assign AIpAdv = w_retire;
  assign ACmdBusy = |r_step;
  assign AStepThis = r_step;
  assign APplListThis = r_ppl;
  assign AWdogTrap = w_trap;
  always_ff @(posedge AClkH or negedge AResetHN)
    if (!AResetHN) begin
      r_step <= '0;
      r_ppl <= '0;
    end else if (AClkHEn && AFlush) begin
      r_step <= '0;
      r_ppl <= '0;
    end else if (w_adv) begin
      r_step <= AStepNext;
      r_ppl <= APplListNext;
    end
`ifdef MS_STEP_WDOG_EN
  logic [WDOG_W-1:0] r_wdog_cnt;
  // the count saturates at the limit because the trap itself blocks further advances
  always_ff @(posedge AClkH or negedge AResetHN)
    if (!AResetHN) r_wdog_cnt <= '0;
    else if (AClkHEn && (AFlush || w_retire)) r_wdog_cnt <= '0;
    else if (w_adv) r_wdog_cnt <= r_wdog_cnt + 1'b1;
  assign w_trap = r_wdog_cnt == WDOG_W'(WDOG_LIMIT);
`else
  logic [WDOG_W-1:0] w_unused_wdog;
  assign w_unused_wdog = '0;
  assign w_trap = 1'b0;
`endif
  ms_unity_hs u_unity (
    .i_clk       (AClkH),
    .i_rst_n     (AResetHN),
    .i_en        (AClkHEn),
    .i_req       (ADecUnityReq),
    .i_len_valid (w_len_valid),
    .i_retire    (w_retire),
    .i_flush     (AFlush),
    .i_gnt       (AUnityGnt),
    .o_unity_req (AUnityReq),
    .o_ack       (w_ack)
  );
endmodule

// File: tb/tb_ms_cmd_seq.sv
// tb_ms_cmd_seq: scoreboard bench for ms_cmd_seq (watchdog checks when MS_STEP_WDOG_EN is defined)
module tb_ms_cmd_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, en, dreq, gnt, mem, flush;
  logic [1:0] qw, len;
  logic [9:0] snext;
  logic [15:0] pnext;
  logic lenv, dack, ureq, ipadv, busy, trap;
  logic [1:0] pop;
  logic [9:0] step;
  logic [15:0] ppl;
  int n_run = 0;
  int n_fail = 0;
  typedef struct {
    logic [1:0] pop;
    logic ipadv, lenv, busy, ureq, uack, trap;
    logic [9:0] step;
    logic [15:0] ppl;
  } exp_t;
  exp_t sb[$];
  int m_ust, m_wcnt;
  logic [9:0] m_step;
  logic [15:0] m_ppl;
  ms_cmd_seq #(.STEP_W(10), .PPL_W(16), .WDOG_LIMIT(8)) dut (
    .AClkH(clk), .AResetHN(rst_n), .AClkHEn(en), .AQueWords(qw), .ACmdLen(len),
    .ACmdLenValid(lenv), .AStepThis(step), .AStepNext(snext), .APplListThis(ppl),
    .APplListNext(pnext), .ADecUnityReq(dreq), .ADecUnityAck(dack), .AUnityReq(ureq),
    .AUnityGnt(gnt), .AMemPend(mem), .AFlush(flush), .AQuePop(pop), .AIpAdv(ipadv),
    .ACmdBusy(busy), .AWdogTrap(trap)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic m_trap();
`ifdef MS_STEP_WDOG_EN
    return m_wcnt == 8;
`else
    return 1'b0;
`endif
  endfunction
  task automatic model_reset();
    m_ust = 0;
    m_wcnt = 0;
    m_step = '0;
    m_ppl = '0;
  endtask
  task automatic cyc();
    exp_t e, g;
    logic lv, ub, adv, ret;
    lv = (len != 0) && (qw >= len);
    ub = dreq && !(m_ust == 2);
    adv = en && lv && !mem && !ub && !flush && !m_trap();
    ret = adv && (snext == 0);
    e.pop = ret ? len : 2'd0;
    e.ipadv = ret;
    e.lenv = lv;
    e.busy = m_step != 0;
    e.ureq = (m_ust == 1) || (m_ust == 2);
    e.uack = m_ust == 2;
    e.trap = m_trap();
    e.step = m_step;
    e.ppl = m_ppl;
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    check("pop", 32'(pop), 32'(g.pop));
    check("ipadv", 32'(ipadv), 32'(g.ipadv));
    check("lenv", 32'(lenv), 32'(g.lenv));
    check("busy", 32'(busy), 32'(g.busy));
    check("ureq", 32'(ureq), 32'(g.ureq));
    check("uack", 32'(dack), 32'(g.uack));
    check("trap", 32'(trap), 32'(g.trap));
    check("step", 32'(step), 32'(g.step));
    check("ppl", 32'(ppl), 32'(g.ppl));
    @(posedge clk);
    if (en) begin
      if (flush) begin
        m_step = '0;
        m_ppl = '0;
        m_wcnt = 0;
      end else if (adv) begin
        m_step = snext;
        m_ppl = pnext;
        m_wcnt = ret ? 0 : m_wcnt + 1;
      end
      if (flush) m_ust = (m_ust == 0) ? 0 : 3;
      else if (m_ust == 0 && dreq && lv) m_ust = 1;
      else if (m_ust == 1 && gnt) m_ust = 2;
      else if (m_ust == 2 && (!dreq || ret)) m_ust = 3;
      else if (m_ust == 3 && !gnt) m_ust = 0;
    end
    @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
  initial begin
    rst_n = 0; en = 1; qw = 0; len = 0; snext = 0; pnext = 0;
    dreq = 0; gnt = 0; mem = 0; flush = 0;
    model_reset();
    #2;
    check("rst_step", 32'(step), 0);
    check("rst_ppl", 32'(ppl), 0);
    check("rst_ureq", 32'(ureq), 0);
    check("rst_ack", 32'(dack), 0);
    check("rst_trap", 32'(trap), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    qw = 2; len = 2; snext = 0; pnext = 16'h1234;
    cyc();
    check("t1_step", 32'(step), 0);
    qw = 1; len = 3;
    repeat (2) cyc();
    qw = 3;
    cyc();
    qw = 1; len = 1; snext = 10'h004; pnext = 16'h00a0;
    cyc();
    check("t3_step_a", 32'(step), 32'h004);
    snext = 10'h010; pnext = 16'h00b0;
    cyc();
    check("t3_step_b", 32'(step), 32'h010);
    snext = 0;
    cyc();
    check("t3_step_c", 32'(step), 0);
    snext = 10'h004; cyc();
    snext = 10'h010; cyc();
    mem = 1; snext = 0;
    repeat (3) cyc();
    check("t4_frozen", 32'(step), 32'h010);
    mem = 0;
    cyc();
    check("t4_resume", 32'(step), 0);
    qw = 2; len = 2; dreq = 1;
    repeat (3) cyc();
    gnt = 1;
    cyc();
    check("t5_ack", 32'(dack), 1);
    cyc();
    cyc();
    gnt = 0; dreq = 0;
    repeat (2) cyc();
    qw = 1; len = 1; snext = 10'h004; cyc();
    snext = 10'h010; cyc();
    dreq = 1;
    repeat (2) cyc();
    gnt = 1;
    repeat (2) cyc();
    check("t6_held", 32'(dack), 1);
    flush = 1;
    cyc();
    check("t6_step", 32'(step), 0);
    check("t6_ureq", 32'(ureq), 0);
    flush = 0; dreq = 0; gnt = 0;
    cyc();
    en = 0; qw = 2; len = 2; snext = 0;
    cyc();
    en = 1; len = 0; qw = 3;
    repeat (2) cyc();
    qw = 1; len = 1; snext = 10'h001;
    repeat (10) cyc();
`ifdef MS_STEP_WDOG_EN
    check("t7_trap", 32'(trap), 1);
    check("t7_frozen", 32'(step), 32'h001);
`endif
    flush = 1;
    cyc();
    flush = 0; snext = 0;
    cyc();
    check("t7_cleared", 32'(trap), 0);
    snext = 10'h004;
    cyc();
    dreq = 1;
    cyc();
    #2;
    rst_n = 0;
    #1;
    check("arst_step", 32'(step), 0);
    check("arst_ureq", 32'(ureq), 0);
    check("arst_busy", 32'(busy), 0);
    model_reset();
    dreq = 0;
    @(negedge clk);
    rst_n = 1;
    snext = 0;
    cyc();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
